mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter and sequencer for the shared single-port data memory in the multiprocessor system. It accepts read/write requests from NUM_REQ processor ports, serialises them onto the memory's read_en/write_en/addr/data_in pins, and waits for valid_out on reads. It then returns read data, or a write acknowledge, to the owning requester. It sits between the processor cores and the memory, and is the only driver of the memory's input pins.

## Interface
- NUM_REQ, 4: number of requester ports (2..8)
- ADDR_WIDTH, 11: memory address width
- DATA_WIDTH, 8: memory data width
- TIMEOUT, 16: max cycles to wait for mem_valid_out on a read (≥2)

Ports:
- clk  in  1  single system clock, all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-port request valid
- req_we  in  NUM_REQ  per-port 1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed per-port address, port i at [i*AW +: AW]
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed per-port write data
- req_ready  out  NUM_REQ  one-hot accept; handshake on valid&&ready
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse to owner
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
- rsp_err  out  1  read timed out, valid with rsp_valid
- mem_read_en  out  1  memory read strobe
- mem_write_en  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_data_in  out  DATA_WIDTH  memory write data
- mem_data_out  in  DATA_WIDTH  memory read data
- mem_valid_out  in  1  memory read-data valid

## Operation
- States: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE: grant the first asserted req_valid at or after pointer ptr, searching upward with wrap. req_ready[g] is combinational and high only in IDLE. On the handshake, latch owner g, we, addr and wdata, then go to ISSUE. With no request, stay in IDLE.
- ptr ← (g+1) mod NUM_REQ on every accepted handshake; reset value is 0.
- ISSUE (exactly 1 cycle): drive mem_addr/mem_data_in from the latches and assert mem_write_en if we, otherwise mem_read_en.
  - Write: go to RESP.
  - Read: clear the timeout counter and go to WAIT_RD.
- WAIT_RD:
  - On mem_valid_out: capture mem_data_out, set err = 0, go to RESP.
  - Otherwise increment the counter. When it reaches TIMEOUT−1 without valid: set rdata = 0, err = 1, go to RESP.
  - The counter is $clog2(TIMEOUT+1) bits wide and saturates.
- RESP (1 cycle): rsp_valid[owner] = 1, drive rsp_rdata/rsp_err, then go to IDLE.
- A write always returns rsp_err = 0 and rsp_rdata = 0.
- mem_valid_out outside WAIT_RD is ignored.
- req_valid/payload must stay stable until ready. Deasserting req_valid before the grant withdraws the request without error.
- Exactly one transaction is outstanding at a time; no pipelining.

## Timing
- Reset (async assert, sync release): state = IDLE, ptr = 0, and all outputs are 0 (req_ready, rsp_valid, rsp_rdata, rsp_err, mem_read_en, mem_write_en, mem_addr, mem_data_in).
- Reset mid-transaction aborts it silently: no rsp_valid, no strobe after reset.
- Accept in cycle T, memory strobe in T+1.
  - Write: rsp_valid in T+2; the next accept is possible in T+3.
  - Read, mem_valid_out sampled in T+1+L (L ≥ 1): rsp_valid in T+2+L.
  - Read with no valid: rsp_err pulse in T+2+TIMEOUT.
- Memory strobes are single-cycle and mutually exclusive. mem_addr/mem_data_in hold the latched values in all states after ISSUE until the next ISSUE.
- Simultaneous requests: exactly one grant per IDLE cycle. No starvation; worst-case wait is NUM_REQ−1 transactions.

## Structure
- Package mp_mem_pkg: ADDR_WIDTH, DATA_WIDTH, NUM_REQ defaults and the arb_state_e enum (IDLE, ISSUE, WAIT_RD, RESP).
- Sub-module rr_arbiter: combinational round-robin select with inputs req[NUM_REQ] and ptr, and outputs one-hot gnt plus binary gnt_idx. The ptr register lives in mem_arbiter.

## Test plan
- Port 2 writes 0xA5 to 0x123 → mem_write_en one cycle with addr 0x123, data 0xA5 → rsp_valid[2] two cycles after accept, rsp_err = 0.
- Port 1 reads 0x123; the memory returns 0xA5 with valid one cycle after read_en → rsp_valid[1] with rsp_rdata = 0xA5, rsp_err = 0, 3 cycles after accept.
- All 4 ports request continuously from reset → grant order 0,1,2,3,0,1…; no port is granted twice before every other active port is served.
- Read with mem_valid_out held low → rsp_valid[owner] with rsp_err = 1 and rsp_rdata = 0 exactly TIMEOUT+2 cycles after accept; the next request is then served normally.
- reset_n pulsed low while in WAIT_RD → all outputs 0 immediately, no response pulse, ptr = 0. A later valid_out is ignored and the next request from port 0 is granted first.
- Spurious mem_valid_out in IDLE and RESP → no rsp_valid, state unaffected.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
// Holds the default geometry of the shared data memory and the
// arbiter FSM state type.
package mp_mem_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_ADDR_WIDTH = 11;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the processor ports, the arbiter and the memory.
//   req_valid/req_we/req_addr/req_wdata : per-port requests (packed, port i
//                                          at [i*W +: W])
//   req_ready                           : one-hot accept
//   rsp_valid/rsp_rdata/rsp_err         : one-hot response pulse + payload
//   mem_read_en/mem_write_en/mem_addr/
//   mem_data_in                         : memory input pins
//   mem_data_out/mem_valid_out          : memory read return
// Modports: master = arbiter view (drives memory pins and responses),
//           slave  = environment view (processors + memory).
interface mem_arbiter_if
    import mp_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_err;
    logic                          mem_read_en;
    logic                          mem_write_en;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [DATA_WIDTH-1:0]         mem_data_in;
    logic [DATA_WIDTH-1:0]         mem_data_out;
    logic                          mem_valid_out;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata,
        input  mem_data_out, mem_valid_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_read_en, mem_write_en, mem_addr, mem_data_in
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata,
        output mem_data_out, mem_valid_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_read_en, mem_write_en, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter.sv
// Combinational round-robin select.
//   req     : request vector
//   ptr     : highest-priority index; search runs upward from it with wrap
//   gnt     : one-hot grant (zero when no request)
//   gnt_idx : binary index of the grant (zero when no request)
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
)(
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx
);

    localparam int unsigned PW = $clog2(NUM_REQ);

    int unsigned idx;
    logic        found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(ptr) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                found     = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port data memory.
// One transaction at a time: accept a request, strobe the memory for one
// cycle, wait for read data (bounded by TIMEOUT), then pulse a response to
// the owning port.
//   clk     : system clock, posedge
//   reset_n : asynchronous active-low reset
//   bus     : master view of mem_arbiter_if (requests, responses, memory pins)
module mem_arbiter
    import mp_mem_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
)(
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.master bus
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_e              state_q;
    logic [PW-1:0]           ptr_q;
    logic [NUM_REQ-1:0]      owner_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [CW-1:0]           cnt_q;

    logic [NUM_REQ-1:0]      gnt;
    logic [PW-1:0]           gnt_idx;
    logic                    accept;
    logic                    sel_we;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req     (bus.req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Payload of the granted port.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PW'(i)) begin
                sel_we    = bus.req_we[i];
                sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept = (state_q == IDLE) && (|gnt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        owner_q <= gnt;
                        we_q    <= sel_we;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        // Writes respond with zero data and no error.
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        ptr_q   <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= we_q ? RESP : WAIT_RD;
                end
                WAIT_RD: begin
                    if (bus.mem_valid_out) begin
                        rdata_q <= bus.mem_data_out;
                        err_q   <= 1'b0;
                        state_q <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        // cnt_q counts completed wait cycles, so this is the
                        // TIMEOUT-th cycle spent here without valid data.
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.req_ready    = (state_q == IDLE) ? gnt : '0;
        bus.rsp_valid    = (state_q == RESP) ? owner_q : '0;
        bus.rsp_rdata    = (state_q == RESP) ? rdata_q : '0;
        bus.rsp_err      = (state_q == RESP) && err_q;
        bus.mem_read_en  = (state_q == ISSUE) && !we_q;
        bus.mem_write_en = (state_q == ISSUE) && we_q;
        bus.mem_addr     = addr_q;
        bus.mem_data_in  = wdata_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (4 ports, 11-bit address,
// 8-bit data, TIMEOUT 16). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_mem_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mem_arbiter_if #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) bus ();

    mem_arbiter #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int passed = 0;

    task automatic clear_inputs();
        bus.req_valid     = '0;
        bus.req_we        = '0;
        bus.req_addr      = '0;
        bus.req_wdata     = '0;
        bus.mem_data_out  = '0;
        bus.mem_valid_out = 1'b0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        bus.req_valid[p]          = 1'b1;
        bus.req_we[p]             = we;
        bus.req_addr[p*AW +: AW]  = a;
        bus.req_wdata[p*DW +: DW] = d;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid} !== 8'h00)
            $display("FAIL reset_ready_rsp: got %h expected 00", {bus.req_ready, bus.rsp_valid});
        else passed++;
        checks++;
        if ({bus.rsp_rdata, bus.rsp_err} !== 9'h000)
            $display("FAIL reset_rdata_err: got %h expected 000", {bus.rsp_rdata, bus.rsp_err});
        else passed++;
        checks++;
        if ({bus.mem_read_en, bus.mem_write_en} !== 2'b00)
            $display("FAIL reset_strobes: got %b expected 00", {bus.mem_read_en, bus.mem_write_en});
        else passed++;
        checks++;
        if ({bus.mem_addr, bus.mem_data_in} !== 19'h0)
            $display("FAIL reset_addr_data: got %h expected 0", {bus.mem_addr, bus.mem_data_in});
        else passed++;
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.mem_read_en, bus.mem_write_en} !== 10'h0)
            $display("FAIL idle_after_reset: got %h expected 0",
                     {bus.req_ready, bus.rsp_valid, bus.mem_read_en, bus.mem_write_en});
        else passed++;
    endtask

    task automatic test_write();
        set_req(2, 1'b1, 11'h123, 8'hA5);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100)
            $display("FAIL wr_ready: got %b expected 0100", bus.req_ready);
        else passed++;
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        checks++;
        if ({bus.mem_write_en, bus.mem_read_en} !== 2'b10)
            $display("FAIL wr_strobe: got %b expected 10", {bus.mem_write_en, bus.mem_read_en});
        else passed++;
        checks++;
        if (bus.mem_addr !== 11'h123 || bus.mem_data_in !== 8'hA5)
            $display("FAIL wr_addr_data: got %h/%h expected 123/a5", bus.mem_addr, bus.mem_data_in);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0100 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 8'h00)
            $display("FAIL wr_rsp: got %b/%b/%h expected 0100/0/00",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        else passed++;
        checks++;
        if (bus.mem_write_en !== 1'b0)
            $display("FAIL wr_strobe_single: got %b expected 0", bus.mem_write_en);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.mem_addr !== 11'h123)
            $display("FAIL wr_after: got %b/%h expected 0000/123", bus.rsp_valid, bus.mem_addr);
        else passed++;
    endtask

    // Pointer sits at 3 after the port-2 write, so port 1 wins by wrap.
    task automatic test_read();
        set_req(1, 1'b0, 11'h123, 8'h00);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010)
            $display("FAIL rd_ready: got %b expected 0010", bus.req_ready);
        else passed++;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        checks++;
        if ({bus.mem_read_en, bus.mem_write_en} !== 2'b10 || bus.mem_addr !== 11'h123)
            $display("FAIL rd_strobe: got %b/%h expected 10/123",
                     {bus.mem_read_en, bus.mem_write_en}, bus.mem_addr);
        else passed++;
        @(negedge clk);
        bus.mem_valid_out = 1'b1;
        bus.mem_data_out  = 8'hA5;
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.mem_read_en !== 1'b0)
            $display("FAIL rd_wait: got %b/%b expected 0000/0", bus.rsp_valid, bus.mem_read_en);
        else passed++;
        @(negedge clk);
        bus.mem_valid_out = 1'b0;
        bus.mem_data_out  = 8'h00;
        checks++;
        if (bus.rsp_valid !== 4'b0010 || bus.rsp_rdata !== 8'hA5 || bus.rsp_err !== 1'b0)
            $display("FAIL rd_rsp: got %b/%h/%b expected 0010/a5/0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0000)
            $display("FAIL rd_rsp_single: got %b expected 0000", bus.rsp_valid);
        else passed++;
    endtask

    task automatic test_round_robin();
        pulse_reset();
        for (int p = 0; p < 4; p++)
            set_req(p, 1'b1, 11'(32'h40 + p), 8'(32'h10 + p));
        for (int n = 0; n < 8; n++) begin
            int w;
            logic [3:0] expg;
            w = 0;
            expg = 4'b0001 << (n % 4);
            #1;
            while (bus.req_ready == 4'b0000 && w < 10) begin
                @(negedge clk);
                w++;
            end
            checks++;
            if (bus.req_ready !== expg)
                $display("FAIL rr_grant_%0d: got %b expected %b", n, bus.req_ready, expg);
            else passed++;
            // Accepts are three cycles apart: two idle-wait steps after ISSUE.
            if (n > 0) begin
                checks++;
                if (w !== 2)
                    $display("FAIL rr_spacing_%0d: got %0d expected 2", n, w);
                else passed++;
            end
            @(negedge clk);
            checks++;
            if (bus.mem_write_en !== 1'b1 || bus.mem_addr !== 11'(32'h40 + (n % 4)))
                $display("FAIL rr_issue_%0d: got %b/%h expected 1/%h",
                         n, bus.mem_write_en, bus.mem_addr, 11'(32'h40 + (n % 4)));
            else passed++;
        end
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout();
        int first;
        int rd_pulses;
        logic [3:0] got_v;
        logic       got_e;
        logic [7:0] got_d;
        first = 0;
        rd_pulses = 0;
        got_v = '0;
        got_e = 1'b0;
        got_d = '0;
        bus.mem_data_out = 8'hEE;
        set_req(3, 1'b0, 11'h055, 8'h00);
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000)
            $display("FAIL to_ready: got %b expected 1000", bus.req_ready);
        else passed++;
        for (int k = 1; k <= int'(TO) + 6; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid[3] = 1'b0;
            if (bus.mem_read_en === 1'b1) rd_pulses++;
            if (bus.rsp_valid !== 4'b0000 && first == 0) begin
                first = k;
                got_v = bus.rsp_valid;
                got_e = bus.rsp_err;
                got_d = bus.rsp_rdata;
            end
        end
        checks++;
        if (first !== int'(TO) + 2)
            $display("FAIL to_latency: got %0d expected %0d", first, TO + 2);
        else passed++;
        checks++;
        if (got_v !== 4'b1000 || got_e !== 1'b1 || got_d !== 8'h00)
            $display("FAIL to_rsp: got %b/%b/%h expected 1000/1/00", got_v, got_e, got_d);
        else passed++;
        checks++;
        if (rd_pulses !== 1)
            $display("FAIL to_read_pulses: got %0d expected 1", rd_pulses);
        else passed++;
        bus.mem_data_out = 8'h00;
        set_req(0, 1'b1, 11'h7FF, 8'h3C);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001)
            $display("FAIL to_next_ready: got %b expected 0001", bus.req_ready);
        else passed++;
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b0)
            $display("FAIL to_next_rsp: got %b/%b expected 0001/0", bus.rsp_valid, bus.rsp_err);
        else passed++;
        @(negedge clk);
    endtask

    // Port 1 is accepted (pointer moves to 2) and then reset hits in WAIT_RD.
    task automatic test_reset_midtx();
        int stray;
        stray = 0;
        set_req(1, 1'b0, 11'h200, 8'h00);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0010)
            $display("FAIL mr_ready: got %b expected 0010", bus.req_ready);
        else passed++;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_read_en, bus.mem_write_en} !== 11'h0 ||
            bus.mem_addr !== 11'h000)
            $display("FAIL mr_outputs_zero: got %h/%h expected 0/000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_read_en, bus.mem_write_en},
                     bus.mem_addr);
        else passed++;
        @(negedge clk);
        bus.mem_valid_out = 1'b1;
        bus.mem_data_out  = 8'h99;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.mem_valid_out = 1'b0;
            if (bus.rsp_valid !== 4'b0000) stray++;
        end
        checks++;
        if (stray !== 0)
            $display("FAIL mr_no_rsp: got %0d response cycles expected 0", stray);
        else passed++;
        set_req(0, 1'b1, 11'h011, 8'h01);
        set_req(2, 1'b1, 11'h022, 8'h02);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001)
            $display("FAIL mr_first_grant: got %b expected 0001", bus.req_ready);
        else passed++;
        @(negedge clk);
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_spurious();
        bus.mem_valid_out = 1'b1;
        bus.mem_data_out  = 8'hFF;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.req_ready !== 4'b0000)
            $display("FAIL sp_idle: got %b/%b expected 0000/0000", bus.rsp_valid, bus.req_ready);
        else passed++;
        set_req(3, 1'b1, 11'h0AA, 8'h5A);
        #1;
        checks++;
        if (bus.req_ready !== 4'b1000)
            $display("FAIL sp_ready: got %b expected 1000", bus.req_ready);
        else passed++;
        @(negedge clk);
        bus.req_valid[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 4'b1000 || bus.rsp_rdata !== 8'h00 || bus.rsp_err !== 1'b0)
            $display("FAIL sp_wr_rsp: got %b/%h/%b expected 1000/00/0",
                     bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
        else passed++;
        @(negedge clk);
        set_req(2, 1'b1, 11'h0BB, 8'h6B);
        #1;
        checks++;
        if (bus.rsp_valid !== 4'b0000 || bus.req_ready !== 4'b0100)
            $display("FAIL sp_after_resp: got %b/%b expected 0000/0100", bus.rsp_valid, bus.req_ready);
        else passed++;
        @(negedge clk);
        clear_inputs();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_timeout();
        test_reset_midtx();
        test_spurious();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
